// File: rtl/umultiplier_pkg.sv
// umultiplier_pkg
//   Shared types for the sequential shift-and-add multiplier.
//   state_t : controller state, 2-bit encoding {IDLE, BUSY, DONE}.
package umultiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : umultiplier_pkg

// File: rtl/umultiplier_if.sv
// umultiplier_if
//   Request/response handshake between requesting logic and the multiplier.
//   start     : level request, sampled by the multiplier only when idle
//   A, B      : unsigned multiplicand / multiplier (WIDTH bits)
//   Z         : product (2*WIDTH bits), holds last result
//   valid_out : one-cycle pulse when Z has just been updated
//   busy_out  : high while an operation is in progress
//   master modport : requester side; slave modport : multiplier side.
interface umultiplier_if #(
   parameter int unsigned WIDTH = 4
);

   logic                 start;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [2*WIDTH-1:0]   Z;
   logic                 valid_out;
   logic                 busy_out;

   modport master (
      output start, A, B,
      input  Z, valid_out, busy_out
   );

   modport slave (
      input  start, A, B,
      output Z, valid_out, busy_out
   );

endinterface : umultiplier_if

// File: rtl/umultiplier.sv
// umultiplier
//   Sequential unsigned shift-and-add multiplier, Z = A * B, over WIDTH cycles.
//   One multiplier bit is tested per cycle; when set, the multiplicand shifted
//   to that bit position is added into a 2*WIDTH-bit accumulator.
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : handshake (slave side): start/A/B in, Z/valid_out/busy_out out
//   inter_out : debug, running partial-product accumulator
//   i_out     : debug, iteration index (bit of B1 under test)
//   A1_out    : debug, latched multiplicand
//   B1_out    : debug, latched multiplier
//   mult_out  : debug, B1[i_out] while busy, else 0
module umultiplier
   import umultiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   umultiplier_if.slave       bus,
   output logic [2*WIDTH-1:0] inter_out,
   output logic [WIDTH-1:0]   i_out,
   output logic [WIDTH-1:0]   A1_out,
   output logic [WIDTH-1:0]   B1_out,
   output logic               mult_out
);

   localparam logic [WIDTH-1:0] LAST_I = WIDTH'(WIDTH - 1);

   state_t               state;
   logic [2*WIDTH-1:0]   inter;
   logic [2*WIDTH-1:0]   inter_next;
   logic [2*WIDTH-1:0]   z_r;
   logic [WIDTH-1:0]     i_r;
   logic [WIDTH-1:0]     a1_r;
   logic [WIDTH-1:0]     b1_r;
   logic [WIDTH-1:0]     bit_mask;
   logic                 mult_bit;

   // Select the multiplier bit under test with a one-hot mask so the index
   // register can keep its full WIDTH-bit debug width.
   always_comb begin
      bit_mask   = WIDTH'(1) << i_r;
      mult_bit   = |(b1_r & bit_mask);
      inter_next = inter;
      if (mult_bit) begin
         inter_next = inter + ({{WIDTH{1'b0}}, a1_r} << i_r);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         inter <= '0;
         z_r   <= '0;
         i_r   <= '0;
         a1_r  <= '0;
         b1_r  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a1_r  <= bus.A;
                  b1_r  <= bus.B;
                  inter <= '0;
                  i_r   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               inter <= inter_next;
               if (i_r == LAST_I) begin
                  z_r   <= inter_next;
                  state <= DONE;
               end else begin
                  i_r <= i_r + WIDTH'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.Z         = z_r;
   assign bus.busy_out  = (state == BUSY);
   assign bus.valid_out = (state == DONE);

   assign inter_out = inter;
   assign i_out     = i_r;
   assign A1_out    = a1_r;
   assign B1_out    = b1_r;
   assign mult_out  = (state == BUSY) ? mult_bit : 1'b0;

endmodule : umultiplier

// File: tb/tb_umultiplier.sv
module tb_umultiplier;

   localparam int unsigned W  = 4;
   localparam int unsigned ZW = 2 * W;

   logic clk;
   logic rst;
   logic [ZW-1:0] inter_out;
   logic [W-1:0]  i_out;
   logic [W-1:0]  A1_out;
   logic [W-1:0]  B1_out;
   logic          mult_out;

   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned n_ops;
   int unsigned n_valid;
   logic [ZW-1:0] z_model;

   umultiplier_if #(.WIDTH(W)) bus ();

   umultiplier #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .inter_out (inter_out),
      .i_out     (i_out),
      .A1_out    (A1_out),
      .B1_out    (B1_out),
      .mult_out  (mult_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.valid_out === 1'b1) n_valid++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_z(input string tag, input logic [ZW-1:0] obs, input logic [ZW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One complete operation. Reference: after k busy edges the accumulator
   // equals A * (B mod 2^k); the product appears after W busy edges.
   // start stays high for start_len cycles from the sampling edge, or for the
   // whole operation (and beyond) when keep is set.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned start_len, input bit keep, input bit scramble);
      int unsigned ia;
      int unsigned ib;
      logic [ZW-1:0] full;
      ia   = a;
      ib   = b;
      full = ZW'(ia * ib);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      n_ops++;
      chk_b("busy_e0",  bus.busy_out,  1'b1);
      chk_b("valid_e0", bus.valid_out, 1'b0);
      chk_z("inter_e0", inter_out, '0);
      chk_w("i_e0",     i_out, '0);
      chk_w("A1_e0",    A1_out, a);
      chk_w("B1_e0",    B1_out, b);
      chk_b("mult_e0",  mult_out, b[0]);
      chk_z("zhold_e0", bus.Z, z_model);
      for (int unsigned k = 1; k <= W; k++) begin
         if (!keep && k >= start_len) bus.start = 1'b0;
         if (scramble) begin
            bus.A = W'($urandom);
            bus.B = W'($urandom);
         end
         @(posedge clk); #1;
         chk_z("inter", inter_out, ZW'(ia * (ib % (1 << k))));
         chk_w("A1", A1_out, a);
         chk_w("B1", B1_out, b);
         if (k < W) begin
            chk_b("busy",  bus.busy_out,  1'b1);
            chk_b("valid", bus.valid_out, 1'b0);
            chk_w("i",     i_out, W'(k));
            chk_b("mult",  mult_out, ((ib >> k) & 1) != 0);
            chk_z("zhold", bus.Z, z_model);
         end else begin
            chk_b("busy_done",  bus.busy_out,  1'b0);
            chk_b("valid_done", bus.valid_out, 1'b1);
            chk_b("mult_done",  mult_out, 1'b0);
            chk_z("z_done",     bus.Z, full);
         end
      end
      z_model = full;
      @(posedge clk); #1;
      chk_b("busy_idle",  bus.busy_out,  1'b0);
      chk_b("valid_idle", bus.valid_out, 1'b0);
      chk_z("z_idle",     bus.Z, z_model);
      if (!keep) bus.start = 1'b0;
   endtask

   initial begin
      int unsigned valid_snap;
      n_cmp = 0; n_err = 0; n_ops = 0; n_valid = 0;
      z_model   = '0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_z("rst_z",     bus.Z, '0);
      chk_z("rst_inter", inter_out, '0);
      chk_w("rst_i",     i_out, '0);
      chk_w("rst_A1",    A1_out, '0);
      chk_w("rst_B1",    B1_out, '0);
      chk_b("rst_busy",  bus.busy_out, 1'b0);
      chk_b("rst_valid", bus.valid_out, 1'b0);
      chk_b("rst_mult",  mult_out, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_b("idle_busy", bus.busy_out, 1'b0);

      // Directed: start held 3 cycles, then 2 cycles; Z holds until completion.
      run_op(4'd4, 4'd2, 3, 1'b0, 1'b0);
      run_op(4'd6, 4'd4, 2, 1'b0, 1'b0);
      run_op(4'd15, 4'd15, 1, 1'b0, 1'b0);
      run_op(4'd0, 4'd9, 1, 1'b0, 1'b0);
      run_op(4'd9, 4'd0, 1, 1'b0, 1'b0);

      // start held continuously: back-to-back operations, operands scrambled mid-op.
      for (int unsigned n = 0; n < 3; n++) run_op(4'd3, 4'd5, 0, 1'b1, 1'b1);
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk_b("b2b_stop_busy", bus.busy_out, 1'b0);

      // Reset in the middle of an operation aborts it without a valid pulse.
      valid_snap = n_valid;
      bus.A = 4'd7; bus.B = 4'd11; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_b("pre_abort_busy", bus.busy_out, 1'b1);
      rst = 1'b1;
      #1;
      chk_z("abort_z",     bus.Z, '0);
      chk_z("abort_inter", inter_out, '0);
      chk_w("abort_i",     i_out, '0);
      chk_w("abort_A1",    A1_out, '0);
      chk_w("abort_B1",    B1_out, '0);
      chk_b("abort_busy",  bus.busy_out, 1'b0);
      chk_b("abort_valid", bus.valid_out, 1'b0);
      chk_b("abort_mult",  mult_out, 1'b0);
      z_model = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_cmp++;
      assert (n_valid == valid_snap) else begin
         n_err++;
         $error("FAIL abort_novalid: observed %0d expected %0d", n_valid, valid_snap);
      end
      run_op(4'd7, 4'd11, 1, 1'b0, 1'b0);

      // Exhaustive operand sweep with randomized start lengths and mid-op noise.
      for (int unsigned x = 0; x < 16; x++) begin
         for (int unsigned y = 0; y < 16; y++) begin
            run_op(W'(x), W'(y), $urandom_range(1, 4), 1'b0, $urandom_range(0, 1) == 1);
         end
      end

      // Random operands with random idle gaps between requests.
      for (int unsigned n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         run_op(W'($urandom), W'($urandom), $urandom_range(1, 5), 1'b0, 1'b1);
      end

      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      assert (n_valid == n_ops) else begin
         n_err++;
         $error("FAIL valid_count: observed %0d expected %0d", n_valid, n_ops);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_umultiplier
